// File: rtl/code_loader_if.sv
// Program stream bundle feeding the code loader.
// One 32-bit beat per handshake; s_last ends a program.
interface code_loader_if;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;

   modport master (
      output s_data,
      output s_valid,
      output s_last,
      input  s_ready
   );

   modport slave (
      input  s_data,
      input  s_valid,
      input  s_last,
      output s_ready
   );
endinterface

// File: rtl/code_loader.sv
// Loads 64-bit instructions from a 32-bit stream into code RAM.
// Halts the CPU first and writes only once it reports idle.
module code_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   code_loader_if.slave          s,
   output logic                  halt_req,
   input  logic                  cpu_idle,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [63:0]           ram_wr_data,
   output logic                  ram_wr_en,
   output logic                  load_done,
   output logic                  err_odd,
   output logic                  err_ovf,
   output logic [ADDR_WIDTH:0]   inst_count
);

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      HI,
      LO,
      FLUSH,
      FINISH
   } state_t;

   localparam logic [ADDR_WIDTH:0] LAST_ADDR =
      (ADDR_WIDTH+1)'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] ONE =
      (ADDR_WIDTH+1)'(1);

   state_t                state_q, state_d;
   logic [31:0]           hi_q, hi_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [63:0]           wr_data_q, wr_data_d;
   logic                  err_odd_q, err_odd_d;
   logic                  err_ovf_q, err_ovf_d;
   logic [ADDR_WIDTH:0]   inst_q, inst_d;
   logic                  rdy;
   logic                  hs;

   // Stream is accepted only in the data phases and never under reset.
   assign rdy = ~rst & ((state_q == HI) |
                        (state_q == LO) |
                        (state_q == FLUSH));
   assign hs  = s.s_valid & rdy;

   assign s.s_ready   = rdy;
   assign halt_req    = (state_q != IDLE);
   assign load_done   = (state_q == FINISH);
   assign ram_wr_en   = wr_en_q & ~rst;
   assign ram_wr_addr = wr_addr_q;
   assign ram_wr_data = wr_data_q;
   assign err_odd     = err_odd_q;
   assign err_ovf     = err_ovf_q;
   assign inst_count  = inst_q;

   // Next-state, write staging and per-load bookkeeping.
   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      err_odd_d = err_odd_q;
      err_ovf_d = err_ovf_q;
      inst_d    = inst_q;
      unique case (state_q)
         IDLE: begin
            if (s.s_valid) state_d = DRAIN;
         end
         DRAIN: begin
            if (cpu_idle) begin
               state_d   = HI;
               cnt_d     = '0;
               err_odd_d = 1'b0;
               err_ovf_d = 1'b0;
            end
         end
         HI: begin
            if (hs) begin
               hi_d = s.s_data;
               if (s.s_last) begin
                  err_odd_d = 1'b1;
                  state_d   = FINISH;
               end else begin
                  state_d = LO;
               end
            end
         end
         LO: begin
            if (hs) begin
               wr_en_d   = 1'b1;
               wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
               wr_data_d = {hi_q, s.s_data};
               cnt_d     = cnt_q + ONE;
               if (s.s_last) begin
                  state_d = FINISH;
               end else if (cnt_q == LAST_ADDR) begin
                  err_ovf_d = 1'b1;
                  state_d   = FLUSH;
               end else begin
                  state_d = HI;
               end
            end
         end
         FLUSH: begin
            if (hs && s.s_last) state_d = FINISH;
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Publish the count as FINISH is entered so it lines up with load_done.
      if (state_q != FINISH && state_d == FINISH) inst_d = cnt_d;
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         hi_q      <= '0;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         err_odd_q <= 1'b0;
         err_ovf_q <= 1'b0;
         inst_q    <= '0;
      end else begin
         state_q   <= state_d;
         hi_q      <= hi_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         err_odd_q <= err_odd_d;
         err_ovf_q <= err_ovf_d;
         inst_q    <= inst_d;
      end
   end

endmodule

// File: doc/code_loader.md
CODE_LOADER -- requirements
Module: code_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, code RAM address width.
REQ-002 SHALL have parameter DEPTH, default 256, number of instruction slots loadable (DEPTH <= 2**ADDR_WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port s_data  input  32  program stream word; first beat of each pair = instruction bits [63:32], second = [31:0].
REQ-006 SHALL have ports s_valid input 1, s_last input 1, s_ready output 1: stream handshake, s_last marks final word of a program.
REQ-007 SHALL have port halt_req  output  1  request that the packet-filter CPU stop fetching.
REQ-008 SHALL have port cpu_idle  input  1  CPU acknowledges it is halted and not reading code RAM.
REQ-009 SHALL have ports ram_wr_addr output ADDR_WIDTH, ram_wr_data output 64, ram_wr_en output 1: code RAM write port.
REQ-010 SHALL have port load_done  output  1  one-cycle pulse at end of every load.
REQ-011 SHALL have ports err_odd output 1, err_ovf output 1: sticky-per-load error flags, valid with load_done.
REQ-012 SHALL have port inst_count  output  ADDR_WIDTH+1  instructions written by the last completed load.

Function
REQ-013 SHALL implement states IDLE, DRAIN, HI, LO, FLUSH, FINISH.
REQ-014 IDLE: s_ready=0, halt_req=0; s_valid=1 -> DRAIN next cycle.
REQ-015 DRAIN: halt_req=1, s_ready=0; cpu_idle=1 sampled -> HI, write address cleared to 0, error flags cleared.
REQ-016 halt_req SHALL stay 1 in DRAIN, HI, LO, FLUSH and FINISH, and drop to 0 the cycle after FINISH.
REQ-017 HI: s_ready=1; on s_valid&s_ready latch s_data into high register; s_last=0 -> LO; s_last=1 -> set err_odd, -> FINISH, nothing written.
REQ-018 LO: s_ready=1; on handshake register ram_wr_data={high, s_data}, ram_wr_addr=current address, ram_wr_en=1 for exactly the next cycle; address increments by 1.
REQ-019 LO handshake with s_last=1 -> FINISH; with s_last=0 and address==DEPTH-1 -> set err_ovf, -> FLUSH; otherwise -> HI.
REQ-020 FLUSH: s_ready=1, accept and discard beats, no RAM writes; handshake with s_last=1 -> FINISH.
REQ-021 FINISH: s_ready=0; load_done=1 for one cycle; inst_count = number of LO writes in this load; -> IDLE.
REQ-022 Write latency SHALL be exactly 1 cycle from LO handshake to ram_wr_en; at most one write per cycle; maximum throughput one instruction per 2 stream beats.
REQ-023 ram_wr_en SHALL never be 1 while cpu_idle has not been sampled high in the current load.
REQ-024 s_valid low in HI/LO/FLUSH SHALL stall the FSM with no state change and no write.
REQ-025 cpu_idle deasserting after DRAIN SHALL be ignored for the rest of the load (CPU is held by halt_req).
REQ-026 ram_wr_data and ram_wr_addr SHALL hold last values when ram_wr_en=0.

Reset
REQ-027 rst=1 SHALL, on the next edge, force IDLE, s_ready=0, halt_req=0, ram_wr_en=0, load_done=0, err_odd=0, err_ovf=0, inst_count=0, ram_wr_addr=0, ram_wr_data=0.
REQ-028 rst asserted mid-load SHALL suppress any pending write (ram_wr_en=0 that cycle) and SHALL NOT pulse load_done.
REQ-029 rst SHALL dominate all other inputs in the same cycle.

Verification
REQ-030 cpu_idle=0 for 10 cycles after s_valid rises -> s_ready=0 and no writes throughout; halt_req=1 from cycle 2 on.
REQ-031 Stream 32 words (16 instructions), cpu_idle=1 -> writes addr 0..15, data {w0,w1}..{w30,w31}; load_done pulse; inst_count=16; errors 0; halt_req low after.
REQ-032 Stream 5 words, last on 5th -> 2 writes, err_odd=1, inst_count=2, load_done pulse.
REQ-033 Stream 520 words with DEPTH=256 -> 256 writes (addr 0..255), remaining 8 words accepted and discarded, err_ovf=1, inst_count=256.
REQ-034 Random s_valid gaps (50%) on a 4-instruction load -> identical RAM contents and inst_count=4 as gap-free run.
REQ-035 rst pulse after 3rd instruction handshake -> no further writes, no load_done, all outputs at reset values; next load restarts at addr 0.
